// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Takes a little-endian byte stream over valid/ready, packs 32-bit words and writes
// them to sequential word addresses. Holds the core in reset until the load finishes,
// and flags words whose opcode the main decoder cannot execute.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   n_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              bad_op,
  output logic [ADDR_W-1:0] bad_idx
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRecv  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Memory capacity in words, also the clamp for oversize load requests.
  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  // Opcodes the single-cycle core's main control decoder understands.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       lane_q,     lane_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic              bad_op_q,   bad_op_d;
  logic [ADDR_W-1:0] bad_idx_q,  bad_idx_d;

  logic start_ok;
  logic accept;
  logic last_word;
  logic op_ok;

  function automatic logic opcode_supported(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OpLoad, OpStore, OpRType, OpBranch, OpImm, OpJal: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Handshake qualifiers and word-level decisions shared by the next-state logic.
  always_comb begin
    start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    accept    = in_valid && (state_q == StRecv);
    last_word = ({1'b0, idx_q} == (count_q - 1'b1));
    op_ok     = opcode_supported(wdata_q[6:0]);
  end

  // Next-state logic for the load sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bad_op_d   = bad_op_q;
    bad_idx_d  = bad_idx_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          count_d    = (n_words > MaxWords) ? MaxWords : n_words;
          idx_d      = '0;
          byte_cnt_d = 2'd0;
          bad_op_d   = 1'b0;
          bad_idx_d  = '0;
          state_d    = (n_words == '0) ? StDone : StRecv;
        end
      end

      StRecv: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: lane_d[7:0]   = in_data;
            2'd1: lane_d[15:8]  = in_data;
            2'd2: lane_d[23:16] = in_data;
            default: begin
              // Top byte goes straight into the write register so the whole word
              // and its address are stable for the single write cycle.
              wdata_d = {in_data, lane_q};
              addr_d  = idx_q;
              state_d = StWrite;
            end
          endcase
        end
      end

      StWrite: begin
        if (!op_ok) begin
          bad_op_d = 1'b1;
          // Only the first offending word is reported.
          if (!bad_op_q) begin
            bad_idx_d = idx_q;
          end
        end
        if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d      = idx_q + 1'b1;
          byte_cnt_d = 2'd0;
          state_d    = StRecv;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= 2'd0;
      lane_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bad_op_q   <= 1'b0;
      bad_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bad_op_q   <= bad_op_d;
      bad_idx_q  <= bad_idx_d;
    end
  end

  // Output decode from the current state; address and data hold between writes.
  always_comb begin
    in_ready   = (state_q == StRecv);
    imem_we    = (state_q == StWrite);
    busy       = (state_q == StRecv) || (state_q == StWrite);
    done       = (state_q == StDone);
    core_rst   = (state_q != StDone);
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    bad_op     = bad_op_q;
    bad_idx    = bad_idx_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Main instance uses ADDR_W=8; a second ADDR_W=2 instance covers count clamping.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] n_words;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       core_rst;
  logic       busy;
  logic       done;
  logic       bad_op;
  logic [7:0] bad_idx;

  logic       s_start;
  logic [2:0] s_n_words;
  logic       s_in_valid;
  logic [7:0] s_in_data;
  logic       s_in_ready;
  logic       s_imem_we;
  logic [1:0] s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic       s_core_rst;
  logic       s_busy;
  logic       s_done;
  logic       s_bad_op;
  logic [1:0] s_bad_idx;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [7:0]  stream[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic        wr_badop[$];
  int          done_cyc;
  int          consumed;
  logic        ready_in_write;
  logic        first_core_rst;
  logic        first_bad_op;
  logic        first_in_ready;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n_words(n_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .bad_op(bad_op), .bad_idx(bad_idx)
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .n_words(s_n_words),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .core_rst(s_core_rst), .busy(s_busy), .done(s_done), .bad_op(s_bad_op),
    .bad_idx(s_bad_idx)
  );

  // Pulse start, then stream bytes from 'stream' and log every write until done.
  // Cycle 0 is the first cycle after the start edge. Called at posedge+1.
  task automatic run_load(input int n, input bit gap, input int budget, output bit timeout);
    int pos;
    bit v;
    pos = 0;
    timeout = 1'b1;
    done_cyc = -1;
    ready_in_write = 1'b0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_badop.delete();
    start = 1'b1;
    n_words = 9'(n);
    @(posedge clk); #1;
    start = 1'b0;
    first_core_rst = core_rst;
    first_bad_op = bad_op;
    first_in_ready = in_ready;
    for (int c = 0; c < budget; c++) begin
      if (imem_we) begin
        wr_addr.push_back(int'(imem_addr));
        wr_data.push_back(imem_wdata);
        wr_cyc.push_back(c);
        wr_badop.push_back(bad_op);
        if (in_ready) ready_in_write = 1'b1;
      end
      if (done) begin
        done_cyc = c;
        timeout = 1'b0;
        break;
      end
      v = (gap && (c % 2 == 1)) ? 1'b0 : (pos < stream.size());
      in_valid = v;
      in_data = v ? stream[pos] : 8'h00;
      if (in_valid && in_ready) pos++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    consumed = pos;
  endtask

  task automatic test_reset();
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    check_cnt++; if (imem_we !== 1'b0) $display("FAIL reset_imem_we got %b exp 0", imem_we); else pass_cnt++;
    check_cnt++; if (imem_addr !== 8'h00) $display("FAIL reset_addr got %h exp 00", imem_addr); else pass_cnt++;
    check_cnt++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", imem_wdata); else pass_cnt++;
    check_cnt++; if (core_rst !== 1'b1) $display("FAIL reset_core_rst got %b exp 1", core_rst); else pass_cnt++;
    check_cnt++; if ({busy, done, bad_op} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, bad_op}); else pass_cnt++;
    check_cnt++; if (bad_idx !== 8'h00) $display("FAIL reset_bad_idx got %h exp 00", bad_idx); else pass_cnt++;
  endtask

  task automatic test_two_word();
    bit to;
    stream = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_load(2, 1'b0, 100, to);
    check_cnt++; if (first_in_ready !== 1'b1) $display("FAIL two_first_ready got %b exp 1", first_in_ready); else pass_cnt++;
    check_cnt++; if (to !== 1'b0) $display("FAIL two_timeout got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (wr_data.size() !== 2) $display("FAIL two_nwrites got %0d exp 2", wr_data.size()); else pass_cnt++;
    if (wr_data.size() == 2) begin
      check_cnt++; if (wr_addr[0] !== 0 || wr_data[0] !== 32'h00500513) $display("FAIL two_w0 got %h@%0d exp 00500513@0", wr_data[0], wr_addr[0]); else pass_cnt++;
      check_cnt++; if (wr_addr[1] !== 1 || wr_data[1] !== 32'h00100593) $display("FAIL two_w1 got %h@%0d exp 00100593@1", wr_data[1], wr_addr[1]); else pass_cnt++;
      check_cnt++; if (wr_cyc[0] !== 4 || wr_cyc[1] !== 9) $display("FAIL two_we_cycles got %0d,%0d exp 4,9", wr_cyc[0], wr_cyc[1]); else pass_cnt++;
    end
    check_cnt++; if (done_cyc !== 10) $display("FAIL two_done_cycle got %0d exp 10", done_cyc); else pass_cnt++;
    check_cnt++; if ({core_rst, busy, bad_op} !== 3'b000) $display("FAIL two_done_flags got %b exp 000", {core_rst, busy, bad_op}); else pass_cnt++;
    check_cnt++; if (imem_addr !== 8'd1 || imem_wdata !== 32'h00100593) $display("FAIL two_hold got %h@%0d exp 00100593@1", imem_wdata, imem_addr); else pass_cnt++;
  endtask

  task automatic test_gapped();
    bit to;
    stream = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_load(2, 1'b1, 100, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL gap_timeout got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (wr_data.size() !== 2) $display("FAIL gap_nwrites got %0d exp 2", wr_data.size()); else pass_cnt++;
    if (wr_data.size() == 2) begin
      check_cnt++; if (wr_addr[0] !== 0 || wr_data[0] !== 32'h00500513) $display("FAIL gap_w0 got %h@%0d exp 00500513@0", wr_data[0], wr_addr[0]); else pass_cnt++;
      check_cnt++; if (wr_addr[1] !== 1 || wr_data[1] !== 32'h00100593) $display("FAIL gap_w1 got %h@%0d exp 00100593@1", wr_data[1], wr_addr[1]); else pass_cnt++;
      check_cnt++; if (wr_cyc[0] !== 7 || wr_cyc[1] !== 15) $display("FAIL gap_we_cycles got %0d,%0d exp 7,15", wr_cyc[0], wr_cyc[1]); else pass_cnt++;
    end
    check_cnt++; if (consumed !== 8) $display("FAIL gap_consumed got %0d exp 8", consumed); else pass_cnt++;
    check_cnt++; if (ready_in_write !== 1'b0) $display("FAIL gap_ready_in_write got %b exp 0", ready_in_write); else pass_cnt++;
  endtask

  task automatic test_bad_opcode();
    bit to;
    stream = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00};
    run_load(3, 1'b0, 100, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL bad_timeout got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (wr_data.size() !== 3) $display("FAIL bad_nwrites got %0d exp 3", wr_data.size()); else pass_cnt++;
    if (wr_data.size() == 3) begin
      check_cnt++; if (wr_data[1] !== 32'h00000037 || wr_addr[1] !== 1) $display("FAIL bad_w1 got %h@%0d exp 00000037@1", wr_data[1], wr_addr[1]); else pass_cnt++;
      check_cnt++; if (wr_data[2] !== 32'h0 || wr_addr[2] !== 2) $display("FAIL bad_w2 got %h@%0d exp 0@2", wr_data[2], wr_addr[2]); else pass_cnt++;
      check_cnt++; if (wr_badop[1] !== 1'b0 || wr_badop[2] !== 1'b1) $display("FAIL bad_timing got %b%b exp 01", wr_badop[1], wr_badop[2]); else pass_cnt++;
    end
    check_cnt++; if (bad_op !== 1'b1) $display("FAIL bad_op_sticky got %b exp 1", bad_op); else pass_cnt++;
    check_cnt++; if (bad_idx !== 8'd1) $display("FAIL bad_idx_first got %0d exp 1", bad_idx); else pass_cnt++;
  endtask

  task automatic test_reload();
    bit to;
    stream = '{8'h6F, 8'h00, 8'h00, 8'h00};
    run_load(1, 1'b0, 100, to);
    check_cnt++; if (first_bad_op !== 1'b0 || first_core_rst !== 1'b1) $display("FAIL reload_first got bad_op=%b core_rst=%b exp 0,1", first_bad_op, first_core_rst); else pass_cnt++;
    check_cnt++; if (wr_data.size() !== 1) $display("FAIL reload_nwrites got %0d exp 1", wr_data.size()); else pass_cnt++;
    if (wr_data.size() == 1) begin
      check_cnt++; if (wr_data[0] !== 32'h0000006F || wr_addr[0] !== 0) $display("FAIL reload_w0 got %h@%0d exp 0000006f@0", wr_data[0], wr_addr[0]); else pass_cnt++;
    end
    check_cnt++; if (to !== 1'b0 || done !== 1'b1 || bad_op !== 1'b0) $display("FAIL reload_done got to=%b done=%b bad_op=%b exp 0,1,0", to, done, bad_op); else pass_cnt++;
  endtask

  task automatic test_count_edges();
    bit to;
    int pos;
    int nw;
    int addrs[$];
    stream.delete();
    run_load(0, 1'b0, 20, to);
    check_cnt++; if (done_cyc !== 0 || wr_data.size() !== 0) $display("FAIL zero_load got done_cyc=%0d writes=%0d exp 0,0", done_cyc, wr_data.size()); else pass_cnt++;
    check_cnt++; if (core_rst !== 1'b0) $display("FAIL zero_core_rst got %b exp 0", core_rst); else pass_cnt++;

    pos = 0;
    nw = 0;
    to = 1'b1;
    s_start = 1'b1;
    s_n_words = 3'd7;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (s_imem_we) begin
        nw++;
        addrs.push_back(int'(s_imem_addr));
      end
      if (s_done) begin
        to = 1'b0;
        break;
      end
      s_in_valid = 1'b1;
      s_in_data = (pos % 4 == 0) ? 8'h13 : 8'h00;
      if (s_in_ready) pos++;
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    check_cnt++; if (to !== 1'b0) $display("FAIL clamp_timeout got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (nw !== 4) $display("FAIL clamp_nwrites got %0d exp 4", nw); else pass_cnt++;
    if (addrs.size() == 4) begin
      check_cnt++; if (addrs[0] !== 0 || addrs[1] !== 1 || addrs[2] !== 2 || addrs[3] !== 3)
        $display("FAIL clamp_addrs got %0d %0d %0d %0d exp 0 1 2 3", addrs[0], addrs[1], addrs[2], addrs[3]);
      else pass_cnt++;
    end
    check_cnt++; if (s_imem_wdata !== 32'h00000013 || s_bad_op !== 1'b0) $display("FAIL clamp_data got %h bad_op=%b exp 00000013,0", s_imem_wdata, s_bad_op); else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    bit to;
    stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00,
               8'h63, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    run_load(4, 1'b0, 12, to);
    check_cnt++; if (wr_data.size() !== 2 || busy !== 1'b1) $display("FAIL mid_before got writes=%0d busy=%b exp 2,1", wr_data.size(), busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    check_cnt++; if ({in_ready, imem_we, busy, done, bad_op} !== 5'b0) $display("FAIL mid_flags got %b exp 00000", {in_ready, imem_we, busy, done, bad_op}); else pass_cnt++;
    check_cnt++; if (imem_addr !== 8'h0 || imem_wdata !== 32'h0 || bad_idx !== 8'h0) $display("FAIL mid_regs got %h %h %h exp 0 0 0", imem_addr, imem_wdata, bad_idx); else pass_cnt++;
    check_cnt++; if (core_rst !== 1'b1) $display("FAIL mid_core_rst got %b exp 1", core_rst); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stream = '{8'h93, 8'h00, 8'h00, 8'h00};
    run_load(1, 1'b0, 100, to);
    check_cnt++; if (wr_data.size() !== 1) $display("FAIL fresh_nwrites got %0d exp 1", wr_data.size()); else pass_cnt++;
    if (wr_data.size() == 1) begin
      check_cnt++; if (wr_data[0] !== 32'h00000093 || wr_addr[0] !== 0) $display("FAIL fresh_w0 got %h@%0d exp 00000093@0", wr_data[0], wr_addr[0]); else pass_cnt++;
    end
    check_cnt++; if (to !== 1'b0 || done !== 1'b1) $display("FAIL fresh_done got to=%b done=%b exp 0,1", to, done); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; n_words = '0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_n_words = '0; s_in_valid = 1'b0; s_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_two_word();
    test_gapped();
    test_bad_opcode();
    test_reload();
    test_count_edges();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory before the single-cycle RISC-V core runs. It accepts a little-endian byte stream through a valid/ready handshake and assembles 32-bit instruction words. Each word is written into instruction memory at sequential word addresses. While loading, it holds the core in reset, and it flags any word whose opcode the main control decoder does not support.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle load request; sampled only in IDLE or DONE
- n_words  in  ADDR_W+1  number of words to load; sampled with start
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  instruction-memory word address
- imem_wdata  out  32  assembled instruction word
- core_rst  out  1  hold core in reset
- busy  out  1  load in progress
- done  out  1  load completed; level signal
- bad_op  out  1  sticky: a loaded word had an unsupported opcode
- bad_idx  out  ADDR_W  word index of the first unsupported word

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - On start, latch count = min(n_words, 2^ADDR_W); clear idx, byte_cnt, bad_op and bad_idx.
  - If count = 0, go to DONE. Otherwise go to RECV.
- **RECV**
  - in_ready = 1.
  - Each in_valid & in_ready handshake stores in_data into byte lane byte_cnt (lane 0 = bits 7:0), then increments byte_cnt.
  - The handshake with byte_cnt = 3 moves to WRITE.
- **WRITE**
  - Lasts exactly one cycle: imem_we = 1, imem_addr = idx, imem_wdata = assembled word. in_ready = 0.
  - Opcode check on bits 6:0. Supported opcodes: 0000011, 0100011, 0110011, 1100011, 0010011, 1101111.
  - On any other opcode, including an all-zero word: set bad_op. If bad_op was previously clear, also capture bad_idx = idx. The word is still written.
  - Next state: DONE if idx = count-1. Otherwise increment idx, clear byte_cnt and go to RECV.
- **DONE**
  - done = 1, core_rst = 0.
  - A start here begins a new load exactly as from IDLE, and core_rst reasserts.
- busy = 1 in RECV and WRITE.
- core_rst = 1 in IDLE, RECV and WRITE.
- start in RECV or WRITE is ignored.
- in_valid while in_ready = 0 is not consumed; the source must hold the byte.
- imem_addr and imem_wdata hold their last values when imem_we = 0. Only imem_we qualifies them.

## Timing
- **Reset values:** state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, busy 0, done 0, bad_op 0, bad_idx 0.
- **Start:** a start pulse seen in cycle t gives in_ready = 1 from cycle t+1.
- **Write latency:** a 4th-byte handshake in cycle t gives imem_we = 1 in cycle t+1. in_ready is 0 in that cycle and returns to 1 in t+2 unless the load is finished.
- **Throughput:** at most one word per 5 cycles with in_valid held high.
- **Completion:** after the final write cycle t, done = 1 and core_rst = 0 from t+1.
- **Zero-word load:** start with n_words = 0 gives done = 1 and core_rst = 0 one cycle later, with no writes.
- **Oversize count:** n_words > 2^ADDR_W is clamped. Addresses never wrap, and the last write goes to address 2^ADDR_W-1.
- **Reset mid-load:** aborts immediately to the reset values. Memory already written is left as is. A partially assembled word is discarded.
- **bad_op / bad_idx:** updated in the WRITE cycle, visible from the next cycle. They hold through DONE until the next start.

## Test plan
- **Two-word load:** start, n_words=2, bytes 13 05 50 00 93 05 10 00 with in_valid held high.
  - Write 0x00500513 @0, then 0x00100593 @1.
  - imem_we pulses 5 cycles apart; done=1 and core_rst=0 one cycle after the 2nd write; bad_op=0.
- **Gapped stream:** same as the two-word load, but in_valid is low every other cycle.
  - Identical writes and data; no byte lost or duplicated; in_ready=0 during WRITE.
- **Unsupported opcode:** three words; word 1 = 0x00000037 (lui), word 2 = 0x00000000.
  - All three words are written.
  - bad_op=1 and bad_idx=1, still 1 after word 2.
- **Count edges:** n_words=0 gives done next cycle with no imem_we. With ADDR_W=2 and n_words=7, exactly 4 writes occur at addresses 0..3, then done.
- **Reset mid-word:** assert rst after 2 bytes of word 3.
  - All outputs go to reset values immediately and core_rst=1.
  - A fresh 1-word load then writes @0 correctly.
- **Reload:** start in DONE with n_words=1 and byte 0x6F first (jal).
  - bad_op clears and core_rst reasserts the next cycle.
  - Word written @0; done returns after the write.
